// File: rtl/csu_pkg.sv
// csu_pkg
//   Definitions shared by the context switch unit and its round-robin
//   selector:
//     csu_state_t   - FSM state encoding (IDLE, SAVE, SELECT, RESTORE)
//     CAUSE_*       - interrupt cause codes; 2'b11 is reserved and acts as
//                     a quantum interrupt
//     CNT_WIDTH     - width of the optional statistics counters
//     is_io_cause() - true for causes that block the interrupted process
package csu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_SELECT  = 2'd2,
      ST_RESTORE = 2'd3
   } csu_state_t;

   localparam logic [1:0] CAUSE_QUANTUM = 2'b00;
   localparam logic [1:0] CAUSE_INPUT   = 2'b01;
   localparam logic [1:0] CAUSE_OUTPUT  = 2'b10;

   localparam int CNT_WIDTH = 16;

   function automatic logic is_io_cause(input logic [1:0] cause);
      return (cause == CAUSE_INPUT) || (cause == CAUSE_OUTPUT);
   endfunction

endpackage

// File: rtl/context_switch_unit_rr_select.sv
// rr_select
//   Combinational round-robin search. Looks for the first set bit of
//   'ready', starting at index 'start' and wrapping from NUM_PROC-1 to 0.
//   Ports:
//     ready [NUM_PROC]   - per-process ready mask
//     start [PROC_WIDTH] - first index to examine
//     sel   [PROC_WIDTH] - first ready index found (0 when none)
//     found              - at least one process is ready
module rr_select
   import csu_pkg::*;
#(
   parameter int NUM_PROC   = 4,
   parameter int PROC_WIDTH = 2
) (
   input  logic [NUM_PROC-1:0]   ready,
   input  logic [PROC_WIDTH-1:0] start,
   output logic [PROC_WIDTH-1:0] sel,
   output logic                  found
);

   int                  idx;
   logic [PROC_WIDTH-1:0] idx_b;

   // Scan from the farthest candidate back to 'start', so the last hit
   // written is the one nearest to 'start' in round-robin order.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      idx_b = '0;
      for (int i = NUM_PROC - 1; i >= 0; i--) begin
         idx   = (int'(start) + i) % NUM_PROC;
         idx_b = idx[PROC_WIDTH-1:0];
         if (ready[idx_b]) begin
            sel   = idx_b;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/context_switch_unit.sv
// context_switch_unit
//   Saves the PC of the interrupted process, chooses the next process that
//   is not blocked on I/O (round-robin), and restores that process's PC.
//
//   State table
//     state      | meaning
//     ST_IDLE    | core runs; an intrpt at a clock edge starts a switch
//     ST_SAVE    | store cur_pc in ctx[proc_id]; I/O causes block proc_id
//     ST_SELECT  | round-robin search; stays here while every process is blocked
//     ST_RESTORE | pc_load pulse with pc_next/proc_id of the chosen process
//
//   Ports:
//     clk, rst_n            - clock; asynchronous active-low reset
//     intrpt, intrpt_cause  - interrupt request and its cause code
//     cur_pc                - PC of the running process
//     io_done, io_done_id   - I/O completion strobe and the process it wakes
//     stall                 - holds the core while a switch is in progress
//     pc_load, pc_next      - one-cycle load strobe and the restored PC
//     proc_id               - running process id
//     blocked               - per-process I/O-blocked flags
//     switch_cnt, drop_cnt  - only with CSU_STATS_EN: saturating counts of
//                             pc_load pulses and of ignored interrupts
//
//   Build option: define CSU_STATS_EN to add the statistics counters.
module context_switch_unit
   import csu_pkg::*;
#(
   parameter int NUM_PROC   = 4,
   parameter int PROC_WIDTH = 2,
   parameter int PC_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  intrpt,
   input  logic [1:0]            intrpt_cause,
   input  logic [PC_WIDTH-1:0]   cur_pc,
   input  logic                  io_done,
   input  logic [PROC_WIDTH-1:0] io_done_id,
   output logic                  stall,
   output logic                  pc_load,
   output logic [PC_WIDTH-1:0]   pc_next,
   output logic [PROC_WIDTH-1:0] proc_id,
   output logic [NUM_PROC-1:0]   blocked
`ifdef CSU_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]  switch_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt
`endif
);

   csu_state_t            state;
   logic [PC_WIDTH-1:0]   ctx [NUM_PROC];
   logic [NUM_PROC-1:0]   blocked_nxt;
   logic [NUM_PROC-1:0]   ready;
   logic [PROC_WIDTH-1:0] start_id;
   logic [PROC_WIDTH-1:0] sel_id;
   logic                  sel_found;

   // The search begins just after the running process and ends on it, so a
   // process that is the only ready one gets reselected.
   assign start_id = (proc_id == PROC_WIDTH'(NUM_PROC - 1)) ? '0
                                                            : proc_id + PROC_WIDTH'(1);
   assign ready    = ~blocked;

   rr_select #(
      .NUM_PROC   (NUM_PROC),
      .PROC_WIDTH (PROC_WIDTH)
   ) u_rr_select (
      .ready (ready),
      .start (start_id),
      .sel   (sel_id),
      .found (sel_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         stall   <= 1'b0;
         pc_load <= 1'b0;
         pc_next <= '0;
         proc_id <= '0;
         for (int i = 0; i < NUM_PROC; i++) begin
            ctx[i] <= '0;
         end
      end else begin
         pc_load <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (intrpt) begin
                  state <= ST_SAVE;
                  stall <= 1'b1;
               end
            end
            ST_SAVE: begin
               ctx[proc_id] <= cur_pc;
               state        <= ST_SELECT;
            end
            ST_SELECT: begin
               if (sel_found) begin
                  state   <= ST_RESTORE;
                  pc_next <= ctx[sel_id];
                  pc_load <= 1'b1;
                  proc_id <= sel_id;
               end
            end
            ST_RESTORE: begin
               state <= ST_IDLE;
               stall <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               stall <= 1'b0;
            end
         endcase
      end
   end

   // The io_done clear is applied after the SAVE set so that it wins when
   // both target the same process in the same cycle.
   always_comb begin
      blocked_nxt = blocked;
      if (state == ST_SAVE && is_io_cause(intrpt_cause)) begin
         blocked_nxt[proc_id] = 1'b1;
      end
      if (io_done) begin
         blocked_nxt[io_done_id] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blocked <= '0;
      end else begin
         blocked <= blocked_nxt;
      end
   end

`ifdef CSU_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         switch_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         if (pc_load && (switch_cnt != '1)) begin
            switch_cnt <= switch_cnt + CNT_WIDTH'(1);
         end
         if (intrpt && (state != ST_IDLE) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
         end
      end
   end
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_context_switch_unit.sv
// tb_context_switch_unit
//   Directed bench for context_switch_unit with hand-computed expectations.
//   Define CSU_STATS_EN for both bench and RTL to also check drop_cnt.
module tb_context_switch_unit;

   logic        clk;
   logic        rst_n;
   logic        intrpt;
   logic [1:0]  intrpt_cause;
   logic [31:0] cur_pc;
   logic        io_done;
   logic [1:0]  io_done_id;
   logic        stall;
   logic        pc_load;
   logic [31:0] pc_next;
   logic [1:0]  proc_id;
   logic [3:0]  blocked;
`ifdef CSU_STATS_EN
   logic [15:0] switch_cnt;
   logic [15:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   context_switch_unit #(
      .NUM_PROC   (4),
      .PROC_WIDTH (2),
      .PC_WIDTH   (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .intrpt       (intrpt),
      .intrpt_cause (intrpt_cause),
      .cur_pc       (cur_pc),
      .io_done      (io_done),
      .io_done_id   (io_done_id),
      .stall        (stall),
      .pc_load      (pc_load),
      .pc_next      (pc_next),
      .proc_id      (proc_id),
      .blocked      (blocked)
`ifdef CSU_STATS_EN
      ,
      .switch_cnt   (switch_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from raising the strobe until pc_load is seen; -1 on timeout.
   task automatic wait_load(input int start, output int lat);
      lat = start;
      while (pc_load !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      if (pc_load !== 1'b1) lat = -1;
   endtask

   task automatic switch_check(input string tag, input logic [31:0] pc, input logic [1:0] cause,
                               input logic [1:0] exp_id, input logic [31:0] exp_pc,
                               input logic [3:0] exp_blk);
      int lat;
      cur_pc       = pc;
      intrpt_cause = cause;
      intrpt       = 1'b1;
      tick();
      intrpt = 1'b0;
      wait_load(1, lat);
      check({tag, "_lat"}, 64'(lat), 64'd3);
      check({tag, "_id"}, 64'(proc_id), 64'(exp_id));
      check({tag, "_pc"}, 64'(pc_next), 64'(exp_pc));
      check({tag, "_blk"}, 64'(blocked), 64'(exp_blk));
      tick();
      check({tag, "_load_off"}, 64'(pc_load), 64'd0);
      check({tag, "_stall_off"}, 64'(stall), 64'd0);
   endtask

   task automatic pulse_io_done(input logic [1:0] id);
      io_done    = 1'b1;
      io_done_id = id;
      tick();
      io_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      logic saw_load;

      rst_n        = 1'b0;
      intrpt       = 1'b0;
      intrpt_cause = 2'b00;
      cur_pc       = '0;
      io_done      = 1'b0;
      io_done_id   = '0;
      tick();
      tick();
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_load", 64'(pc_load), 64'd0);
      check("rst_pc", 64'(pc_next), 64'd0);
      check("rst_id", 64'(proc_id), 64'd0);
      check("rst_blk", 64'(blocked), 64'd0);
      rst_n = 1'b1;

      // Quantum switch 0 -> 1, then I/O block of 1 -> 2.
      switch_check("quantum", 32'h100, 2'b00, 2'd1, 32'h0, 4'b0000);
      switch_check("io_blk1", 32'h200, 2'b01, 2'd2, 32'h0, 4'b0010);
      pulse_io_done(2'd1);
      check("io_done1", 64'(blocked), 64'd0);

      // Block every process in turn.
      switch_check("blk_p2", 32'h300, 2'b10, 2'd3, 32'h0,   4'b0100);
      switch_check("blk_p3", 32'h400, 2'b01, 2'd0, 32'h100, 4'b1100);
      switch_check("blk_p0", 32'h500, 2'b01, 2'd1, 32'h200, 4'b1101);
      cur_pc       = 32'h600;
      intrpt_cause = 2'b10;
      intrpt       = 1'b1;
      tick();
      intrpt   = 1'b0;
      saw_load = 1'b0;
      repeat (6) begin
         tick();
         if (pc_load === 1'b1) saw_load = 1'b1;
      end
      check("allblk_load", 64'(saw_load), 64'd0);
      check("allblk_stall", 64'(stall), 64'd1);
      check("allblk_blk", 64'(blocked), 64'hF);

      // Interrupt while stuck in SELECT is dropped.
      intrpt_cause = 2'b00;
      intrpt       = 1'b1;
      tick();
      intrpt = 1'b0;
      tick();
      check("drop_stall", 64'(stall), 64'd1);
      check("drop_load", 64'(pc_load), 64'd0);
      check("drop_id", 64'(proc_id), 64'd1);
`ifdef CSU_STATS_EN
      check("drop_cnt", 64'(drop_cnt), 64'd1);
`endif

      // Waking process 2 releases the search one cycle after the clear.
      io_done    = 1'b1;
      io_done_id = 2'd2;
      tick();
      io_done = 1'b0;
      wait_load(1, lat);
      check("wake_lat", 64'(lat), 64'd2);
      check("wake_id", 64'(proc_id), 64'd2);
      check("wake_pc", 64'(pc_next), 64'h300);
      check("wake_blk", 64'(blocked), 64'b1011);
      tick();
      check("wake_stall_off", 64'(stall), 64'd0);
      repeat (3) tick();
      check("no_queue", 64'(stall), 64'd0);

      // Wrap to 3, then self-select with 0-2 blocked.
      pulse_io_done(2'd3);
      check("io_done3", 64'(blocked), 64'b0011);
      switch_check("to_p3", 32'h700, 2'b01, 2'd3, 32'h400, 4'b0111);
      switch_check("self", 32'h800, 2'b00, 2'd3, 32'h800, 4'b0111);

      // io_done for the process being blocked in SAVE: the clear wins.
      cur_pc       = 32'h900;
      intrpt_cause = 2'b01;
      intrpt       = 1'b1;
      tick();
      intrpt     = 1'b0;
      io_done    = 1'b1;
      io_done_id = 2'd3;
      tick();
      io_done = 1'b0;
      check("clr_win_blk", 64'(blocked), 64'b0111);
      tick();
      check("clr_win_load", 64'(pc_load), 64'd1);
      check("clr_win_id", 64'(proc_id), 64'd3);
      check("clr_win_pc", 64'(pc_next), 64'h900);
      tick();
      check("clr_win_stall", 64'(stall), 64'd0);

      // Asynchronous reset in SAVE.
      cur_pc       = 32'hA00;
      intrpt_cause = 2'b00;
      intrpt       = 1'b1;
      tick();
      intrpt = 1'b0;
      check("save_stall", 64'(stall), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_stall", 64'(stall), 64'd0);
      check("arst_load", 64'(pc_load), 64'd0);
      check("arst_pc", 64'(pc_next), 64'd0);
      check("arst_id", 64'(proc_id), 64'd0);
      check("arst_blk", 64'(blocked), 64'd0);
`ifdef CSU_STATS_EN
      check("arst_drop", 64'(drop_cnt), 64'd0);
`endif

      // First interrupt after reset release is taken at the first edge;
      // ctx[1] reads back as 0 because reset cleared the table.
      @(negedge clk);
      rst_n        = 1'b1;
      cur_pc       = 32'hB00;
      intrpt_cause = 2'b00;
      intrpt       = 1'b1;
      tick();
      intrpt = 1'b0;
      check("post_rst_stall", 64'(stall), 64'd1);
      wait_load(1, lat);
      check("post_rst_lat", 64'(lat), 64'd3);
      check("post_rst_id", 64'(proc_id), 64'd1);
      check("post_rst_pc", 64'(pc_next), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
